if_id_buffer: RTL and testbench

Instruction-fetch to decode buffer that sits directly downstream of the PC register and instruction memory. Each cycle it accepts one fetched {pc, inst} pair and holds it in a small in-order FIFO. It presents the oldest entry to the decode stage with a valid/ready handshake. When the FIFO fills it raises `pc_stop` to freeze the PC, and on a branch/jump redirect (`flush`) it discards every buffered instruction in one cycle.

---
 rtl/if_id_buffer.sv | 104 ++++++++++
 tb/tb_if_id_buffer.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/if_id_buffer.sv
// if_id_buffer: in-order fetch-to-decode FIFO of {pc, inst} pairs.
// Raises pc_stop while full so the PC register holds, and drops every
// buffered instruction in a single cycle on a redirect (flush).
module if_id_buffer #(
  parameter int DEPTH = 2,
  parameter int XLEN  = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       if_valid,
  input  logic [XLEN-1:0]            if_pc,
  input  logic [XLEN-1:0]            if_inst,
  output logic                       if_ready,
  output logic                       pc_stop,
  input  logic                       flush,
  output logic                       id_valid,
  output logic [XLEN-1:0]            id_pc,
  output logic [XLEN-1:0]            id_inst,
  output logic [XLEN-1:0]            id_pc4,
  input  logic                       id_ready,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [XLEN-1:0] NOP_INST = XLEN'(32'h0000_0013);

  logic [XLEN-1:0] pc_mem_r   [DEPTH];
  logic [XLEN-1:0] inst_mem_r [DEPTH];
  logic [PW-1:0]   wr_ptr_r;
  logic [PW-1:0]   rd_ptr_r;
  logic [CW-1:0]   count_r;

  logic full_s;
  logic empty_s;
  logic push_s;
  logic pop_s;

  // Occupancy flags and the qualified push/pop strobes; flush masks both.
  always_comb begin
    full_s  = (count_r == CW'(DEPTH));
    empty_s = (count_r == {CW{1'b0}});
    push_s  = if_valid & ~full_s & ~flush;
    pop_s   = ~empty_s & id_ready & ~flush;
  end

  // Pointer and occupancy update; flush returns the buffer to its empty state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_r <= {PW{1'b0}};
      rd_ptr_r <= {PW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else if (flush) begin
      wr_ptr_r <= {PW{1'b0}};
      rd_ptr_r <= {PW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PW'(1);
      end else begin
        wr_ptr_r <= wr_ptr_r;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PW'(1);
      end else begin
        rd_ptr_r <= rd_ptr_r;
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Entry storage; contents are don't-care once the slot is not occupied.
  always_ff @(posedge clk) begin
    if (push_s) begin
      pc_mem_r[wr_ptr_r]   <= if_pc;
      inst_mem_r[wr_ptr_r] <= if_inst;
    end else begin
      pc_mem_r[wr_ptr_r]   <= pc_mem_r[wr_ptr_r];
      inst_mem_r[wr_ptr_r] <= inst_mem_r[wr_ptr_r];
    end
  end

  // Head presentation: the oldest entry, or a NOP bubble with zeroed pc when empty.
  always_comb begin
    if_ready = ~full_s;
    pc_stop  = full_s & ~flush;
    id_valid = ~empty_s;
    count    = count_r;
    if (empty_s) begin
      id_pc   = {XLEN{1'b0}};
      id_inst = NOP_INST;
      id_pc4  = {XLEN{1'b0}};
    end else begin
      id_pc   = pc_mem_r[rd_ptr_r];
      id_inst = inst_mem_r[rd_ptr_r];
      id_pc4  = pc_mem_r[rd_ptr_r] + XLEN'(4);
    end
  end

endmodule

// File: tb/tb_if_id_buffer.sv
// tb_if_id_buffer: vector table, directed corner sequences and a random
// run against a queue-based reference model of the fetch/decode buffer.
module tb_if_id_buffer;

  localparam int DEPTH = 2;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_inst;
  logic        if_ready;
  logic        pc_stop;
  logic        flush;
  logic        id_valid;
  logic [31:0] id_pc;
  logic [31:0] id_inst;
  logic [31:0] id_pc4;
  logic        id_ready;
  logic [1:0]  count;

  int checks = 0;
  int errors = 0;

  logic [63:0] q[$];

  if_id_buffer #(.DEPTH(DEPTH), .XLEN(32)) dut (
    .clk(clk), .rst(rst), .if_valid(if_valid), .if_pc(if_pc), .if_inst(if_inst),
    .if_ready(if_ready), .pc_stop(pc_stop), .flush(flush), .id_valid(id_valid),
    .id_pc(id_pc), .id_inst(id_inst), .id_pc4(id_pc4), .id_ready(id_ready),
    .count(count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        v;
    logic [31:0] pc;
    logic [31:0] inst;
    logic        fl;
    logic        rd;
    logic [1:0]  c;
    logic        ev;
    logic [31:0] epc;
    logic [31:0] einst;
    logic [31:0] epc4;
    logic        eir;
    logic        eps;
  } vec_t;

  vec_t tbl[12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] inst,
                       input logic fl, input logic rd);
    if_valid = v;
    if_pc    = pc;
    if_inst  = inst;
    flush    = fl;
    id_ready = rd;
  endtask

  // Compare every output against the reference queue.
  task automatic check_model(input string tag);
    int sz;
    logic [31:0] hpc;
    logic [31:0] hinst;
    sz    = q.size();
    hpc   = (sz > 0) ? q[0][63:32] : 32'd0;
    hinst = (sz > 0) ? q[0][31:0]  : NOP;
    chk({tag, "_count"},    {30'd0, count}, 32'(sz));
    chk({tag, "_id_valid"}, {31'd0, id_valid}, {31'd0, (sz > 0)});
    chk({tag, "_id_pc"},    id_pc, hpc);
    chk({tag, "_id_inst"},  id_inst, hinst);
    chk({tag, "_id_pc4"},   id_pc4, (sz > 0) ? hpc + 32'd4 : 32'd0);
    chk({tag, "_if_ready"}, {31'd0, if_ready}, {31'd0, (sz < DEPTH)});
    chk({tag, "_pc_stop"},  {31'd0, pc_stop}, {31'd0, (sz == DEPTH) && !flush});
    chk({tag, "_count_bound"}, {31'd0, (count <= 2'(DEPTH))}, 32'd1);
  endtask

  initial begin
    // Stream, backpressure fill, drain while full and pointer wrap.
    tbl[0]  = '{1'b1, 32'h0, 32'h00100093, 1'b0, 1'b1, 2'd1, 1'b1, 32'h0, 32'h00100093, 32'h4,  1'b1, 1'b0};
    tbl[1]  = '{1'b1, 32'h4, 32'h00200113, 1'b0, 1'b1, 2'd1, 1'b1, 32'h4, 32'h00200113, 32'h8,  1'b1, 1'b0};
    tbl[2]  = '{1'b1, 32'h8, 32'h00300193, 1'b0, 1'b1, 2'd1, 1'b1, 32'h8, 32'h00300193, 32'hC,  1'b1, 1'b0};
    tbl[3]  = '{1'b1, 32'hC, 32'h00400213, 1'b0, 1'b1, 2'd1, 1'b1, 32'hC, 32'h00400213, 32'h10, 1'b1, 1'b0};
    tbl[4]  = '{1'b0, 32'h0, 32'h0,        1'b0, 1'b1, 2'd0, 1'b0, 32'h0, NOP,          32'h0,  1'b1, 1'b0};
    tbl[5]  = '{1'b1, 32'h0, 32'h00100093, 1'b0, 1'b0, 2'd1, 1'b1, 32'h0, 32'h00100093, 32'h4,  1'b1, 1'b0};
    tbl[6]  = '{1'b1, 32'h4, 32'h00200113, 1'b0, 1'b0, 2'd2, 1'b1, 32'h0, 32'h00100093, 32'h4,  1'b0, 1'b1};
    tbl[7]  = '{1'b1, 32'h8, 32'h00300193, 1'b0, 1'b0, 2'd2, 1'b1, 32'h0, 32'h00100093, 32'h4,  1'b0, 1'b1};
    tbl[8]  = '{1'b1, 32'h8, 32'h00300193, 1'b0, 1'b1, 2'd1, 1'b1, 32'h4, 32'h00200113, 32'h8,  1'b1, 1'b0};
    tbl[9]  = '{1'b1, 32'h8, 32'h00300193, 1'b0, 1'b0, 2'd2, 1'b1, 32'h4, 32'h00200113, 32'h8,  1'b0, 1'b1};
    tbl[10] = '{1'b0, 32'h0, 32'h0,        1'b0, 1'b1, 2'd1, 1'b1, 32'h8, 32'h00300193, 32'hC,  1'b1, 1'b0};
    tbl[11] = '{1'b0, 32'h0, 32'h0,        1'b0, 1'b1, 2'd0, 1'b0, 32'h0, NOP,          32'h0,  1'b1, 1'b0};

    // Reset state.
    rst = 1'b1;
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    @(posedge clk); #1;
    chk("rst_count",    {30'd0, count}, 32'd0);
    chk("rst_id_valid", {31'd0, id_valid}, 32'd0);
    chk("rst_id_pc",    id_pc, 32'd0);
    chk("rst_id_inst",  id_inst, NOP);
    chk("rst_id_pc4",   id_pc4, 32'd0);
    chk("rst_if_ready", {31'd0, if_ready}, 32'd1);
    chk("rst_pc_stop",  {31'd0, pc_stop}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 12; i++) begin
      drive(tbl[i].v, tbl[i].pc, tbl[i].inst, tbl[i].fl, tbl[i].rd);
      @(posedge clk); #1;
      chk($sformatf("vec%0d_count", i),    {30'd0, count}, {30'd0, tbl[i].c});
      chk($sformatf("vec%0d_id_valid", i), {31'd0, id_valid}, {31'd0, tbl[i].ev});
      chk($sformatf("vec%0d_id_pc", i),    id_pc, tbl[i].epc);
      chk($sformatf("vec%0d_id_inst", i),  id_inst, tbl[i].einst);
      chk($sformatf("vec%0d_id_pc4", i),   id_pc4, tbl[i].epc4);
      chk($sformatf("vec%0d_if_ready", i), {31'd0, if_ready}, {31'd0, tbl[i].eir});
      chk($sformatf("vec%0d_pc_stop", i),  {31'd0, pc_stop}, {31'd0, tbl[i].eps});
    end

    // Flush while full, with a simultaneous push and pop request.
    drive(1'b1, 32'h10, 32'h00500293, 1'b0, 1'b0);
    @(posedge clk); #1;
    drive(1'b1, 32'h14, 32'h00600313, 1'b0, 1'b0);
    @(posedge clk); #1;
    chk("fl_pre_count", {30'd0, count}, 32'd2);
    drive(1'b1, 32'h18, 32'h00700393, 1'b1, 1'b1);
    #1;
    chk("fl_pc_stop_low", {31'd0, pc_stop}, 32'd0);
    @(posedge clk); #1;
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    #1;
    chk("fl_count",    {30'd0, count}, 32'd0);
    chk("fl_id_valid", {31'd0, id_valid}, 32'd0);
    chk("fl_id_inst",  id_inst, NOP);
    chk("fl_if_ready", {31'd0, if_ready}, 32'd1);

    // Asynchronous reset between clock edges while full.
    drive(1'b1, 32'h20, 32'h00800413, 1'b0, 1'b0);
    @(posedge clk); #1;
    drive(1'b1, 32'h24, 32'h00900493, 1'b0, 1'b0);
    @(posedge clk); #1;
    chk("ar_pre_count", {30'd0, count}, 32'd2);
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    chk("ar_id_valid", {31'd0, id_valid}, 32'd0);
    chk("ar_count",    {30'd0, count}, 32'd0);
    chk("ar_if_ready", {31'd0, if_ready}, 32'd1);
    chk("ar_id_inst",  id_inst, NOP);
    @(negedge clk);
    rst = 1'b0;
    drive(1'b1, 32'h30, 32'h00a00513, 1'b0, 1'b0);
    @(posedge clk); #1;
    chk("ar_first_push_count", {30'd0, count}, 32'd1);
    chk("ar_first_push_pc",    id_pc, 32'h30);

    // pc + 4 wraps to zero at the top of the address space.
    drive(1'b1, 32'hFFFF_FFFC, 32'h00b00593, 1'b0, 1'b1);
    @(posedge clk); #1;
    chk("wrap_id_pc",   id_pc, 32'hFFFF_FFFC);
    chk("wrap_id_pc4",  id_pc4, 32'h0000_0000);

    // Empty the buffer, then random traffic against the reference queue.
    drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    @(posedge clk); #1;
    q.delete();
    check_model("rnd_start");
    for (int n = 0; n < 3000; n++) begin
      bit do_pop;
      bit do_push;
      drive(($urandom_range(3) != 0), $urandom, $urandom,
            ($urandom_range(19) == 0), ($urandom_range(4) < 3));
      if (flush) begin
        q.delete();
      end else begin
        do_pop  = (q.size() > 0) && id_ready;
        do_push = if_valid && (q.size() < DEPTH);
        if (do_pop) void'(q.pop_front());
        if (do_push) q.push_back({if_pc, if_inst});
      end
      @(posedge clk); #1;
      check_model("rnd");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
